// File: rtl/multiply_add_pipe_if.sv
// ---------------------------------------------------------------------------
// multiply_add_pipe_if
// Handshake/operand bundle for multiply_add_pipe.
//   in_valid/in_ready   : operand-side valid/ready handshake
//   a, b                : WIDTH-bit multiplicand / multiplier
//   c                   : 2*WIDTH-bit addend
//   signed_op           : 1 = two's complement operation, 0 = unsigned
//   out_valid/out_ready : result-side valid/ready handshake
//   o                   : 2*WIDTH-bit result
//   acc_sel, acc_clr    : accumulator controls, present only with MULADD_ACC_EN
// Modports: slave = the pipeline, master = the operand source / result sink.
// Optional feature macro: MULADD_ACC_EN
// ---------------------------------------------------------------------------
interface multiply_add_pipe_if #(
  parameter int WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   c;
  logic                 signed_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   o;
`ifdef MULADD_ACC_EN
  logic                 acc_sel;
  logic                 acc_clr;

  modport slave (
    input  in_valid, a, b, c, signed_op, out_ready, acc_sel, acc_clr,
    output in_ready, out_valid, o
  );
  modport master (
    output in_valid, a, b, c, signed_op, out_ready, acc_sel, acc_clr,
    input  in_ready, out_valid, o
  );
`else
  modport slave (
    input  in_valid, a, b, c, signed_op, out_ready,
    output in_ready, out_valid, o
  );
  modport master (
    output in_valid, a, b, c, signed_op, out_ready,
    input  in_ready, out_valid, o
  );
`endif
endinterface

// File: rtl/multiply_add_pipe.sv
// ---------------------------------------------------------------------------
// multiply_add_pipe
// Pipelined multiply-add, o = a*b + c, unsigned or signed per operation,
// one operation per clock with a global stall under output backpressure.
// Parameters:
//   WIDTH : width of a and b; c and o are 2*WIDTH
//   LAT   : clocks from accept to out_valid, legal range 2..8
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multiply_add_pipe_if.slave (handshakes, operands, result)
// Optional feature macro: MULADD_ACC_EN adds a 2*WIDTH accumulator that an
// operation can use as its addend (acc_sel) or replace by zero (acc_clr).
// Pipeline: stage 1 registers operands, stages 2..LAT-1 carry the product,
// stage LAT is the output register where the addend is applied.
// ---------------------------------------------------------------------------
module multiply_add_pipe #(
  parameter int WIDTH = 64,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  multiply_add_pipe_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int NP = (LAT > 2) ? (LAT - 2) : 1;

  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;
  logic [W2-1:0]     r_s1_c;
  logic              r_s1_signed;
`ifdef MULADD_ACC_EN
  logic              r_s1_sel;
  logic              r_s1_clr;
  logic              w_last_sel;
  logic              w_last_clr;
  logic [W2-1:0]     r_acc;
`endif

  logic              r_o_valid;
  logic [W2-1:0]     r_o;

  logic              w_advance;
  logic [W2-1:0]     w_a_ext;
  logic [W2-1:0]     w_b_ext;
  logic [W2-1:0]     w_prod;
  logic              w_last_valid;
  logic [W2-1:0]     w_last_prod;
  logic [W2-1:0]     w_last_c;
  logic [W2-1:0]     w_addend;
  logic [W2-1:0]     w_o_next;

  // The whole pipe moves together: it only stalls when a result sits in the
  // output register and downstream refuses it.
  assign w_advance     = ~r_o_valid | bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_o_valid;
  assign bus.o         = r_o;

  // Stage 1: operand capture. Data is captured only on advance so a stalled
  // operation never sees later input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_c      <= '0;
      r_s1_signed <= 1'b0;
`ifdef MULADD_ACC_EN
      r_s1_sel    <= 1'b0;
      r_s1_clr    <= 1'b0;
`endif
    end else if (w_advance) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_a      <= bus.a;
      r_s1_b      <= bus.b;
      r_s1_c      <= bus.c;
      r_s1_signed <= bus.signed_op;
`ifdef MULADD_ACC_EN
      r_s1_sel    <= bus.acc_sel;
      r_s1_clr    <= bus.acc_clr;
`endif
    end
  end

  // Sign- or zero-extending both operands to 2*WIDTH makes one unsigned
  // 2*WIDTH multiplier give the correct low 2*WIDTH bits for either mode.
  assign w_a_ext = {{WIDTH{r_s1_signed & r_s1_a[WIDTH-1]}}, r_s1_a};
  assign w_b_ext = {{WIDTH{r_s1_signed & r_s1_b[WIDTH-1]}}, r_s1_b};
  assign w_prod  = w_a_ext * w_b_ext;

  if (LAT > 2) begin : g_pipe
    logic          r_p_valid [NP];
    logic [W2-1:0] r_p_prod  [NP];
    logic [W2-1:0] r_p_c     [NP];
`ifdef MULADD_ACC_EN
    logic          r_p_sel   [NP];
    logic          r_p_clr   [NP];
`endif

    // Product stages: shift one place per advance, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NP; i++) begin
          r_p_valid[i] <= 1'b0;
          r_p_prod[i]  <= '0;
          r_p_c[i]     <= '0;
`ifdef MULADD_ACC_EN
          r_p_sel[i]   <= 1'b0;
          r_p_clr[i]   <= 1'b0;
`endif
        end
      end else if (w_advance) begin
        r_p_valid[0] <= r_s1_valid;
        r_p_prod[0]  <= w_prod;
        r_p_c[0]     <= r_s1_c;
`ifdef MULADD_ACC_EN
        r_p_sel[0]   <= r_s1_sel;
        r_p_clr[0]   <= r_s1_clr;
`endif
        for (int i = 1; i < NP; i++) begin
          r_p_valid[i] <= r_p_valid[i-1];
          r_p_prod[i]  <= r_p_prod[i-1];
          r_p_c[i]     <= r_p_c[i-1];
`ifdef MULADD_ACC_EN
          r_p_sel[i]   <= r_p_sel[i-1];
          r_p_clr[i]   <= r_p_clr[i-1];
`endif
        end
      end
    end

    assign w_last_valid = r_p_valid[NP-1];
    assign w_last_prod  = r_p_prod[NP-1];
    assign w_last_c     = r_p_c[NP-1];
`ifdef MULADD_ACC_EN
    assign w_last_sel   = r_p_sel[NP-1];
    assign w_last_clr   = r_p_clr[NP-1];
`endif
  end else begin : g_direct
    // LAT=2: multiply and add share the output stage.
    assign w_last_valid = r_s1_valid;
    assign w_last_prod  = w_prod;
    assign w_last_c     = r_s1_c;
`ifdef MULADD_ACC_EN
    assign w_last_sel   = r_s1_sel;
    assign w_last_clr   = r_s1_clr;
`endif
  end

  // The accumulator is read when the operation reaches the output stage, so
  // back-to-back operations chain through each other's results in order.
`ifdef MULADD_ACC_EN
  assign w_addend = w_last_clr ? '0 : (w_last_sel ? r_acc : w_last_c);
`else
  assign w_addend = w_last_c;
`endif
  assign w_o_next = w_last_prod + w_addend;

  // Output register: o only reloads for a real result, so it keeps its value
  // across bubbles as well as stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      r_o       <= '0;
    end else if (w_advance) begin
      r_o_valid <= w_last_valid;
      if (w_last_valid) begin
        r_o <= w_o_next;
      end
    end
  end

`ifdef MULADD_ACC_EN
  // Accumulator follows every result that loads into o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_advance && w_last_valid) begin
      r_acc <= w_o_next;
    end
  end
`endif

endmodule
